sram_axi_bridge: RTL and testbench

SRAM_AXI_BRIDGE -- requirements
Module: sram_axi_bridge

---
 rtl/sram_axi_bridge.sv | 248 ++++++++++++++++++++++++
 tb/tb_sram_axi_bridge.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/sram_axi_bridge.sv
`default_nettype none
// ============================================================================
// Module      : sram_axi_bridge
// Description : Bridges an SRAM-style inst/data request pair onto a single
//               AXI3 master port using single-beat transactions only.
// Revision    : 1.0  initial release
// ============================================================================
module sram_axi_bridge #(
  parameter logic [3:0] ARID_INST = 4'd0,
  parameter logic [3:0] ARID_DATA = 4'd1
) (
  input  logic        aclk,
  input  logic        areset,
  // instruction port
  input  logic        inst_req,
  input  logic [1:0]  inst_size,
  input  logic [31:0] inst_addr,
  output logic        inst_addr_ok,
  output logic        inst_data_ok,
  output logic [31:0] inst_rdata,
  // data port
  input  logic        data_req,
  input  logic        data_wr,
  input  logic [1:0]  data_size,
  input  logic [31:0] data_addr,
  input  logic [31:0] data_wdata,
  output logic        data_addr_ok,
  output logic        data_data_ok,
  output logic [31:0] data_rdata,
  // AR channel
  output logic [3:0]  arid,
  output logic [31:0] araddr,
  output logic [7:0]  arlen,
  output logic [2:0]  arsize,
  output logic [1:0]  arburst,
  output logic [1:0]  arlock,
  output logic [3:0]  arcache,
  output logic [2:0]  arprot,
  output logic        arvalid,
  input  logic        arready,
  // R channel
  input  logic [3:0]  rid,
  input  logic [31:0] rdata,
  input  logic [1:0]  rresp,
  input  logic        rlast,
  input  logic        rvalid,
  output logic        rready,
  // AW channel
  output logic [3:0]  awid,
  output logic [31:0] awaddr,
  output logic [7:0]  awlen,
  output logic [2:0]  awsize,
  output logic [1:0]  awburst,
  output logic [1:0]  awlock,
  output logic [3:0]  awcache,
  output logic [2:0]  awprot,
  output logic        awvalid,
  input  logic        awready,
  // W channel
  output logic [3:0]  wid,
  output logic [31:0] wdata,
  output logic [3:0]  wstrb,
  output logic        wlast,
  output logic        wvalid,
  input  logic        wready,
  // B channel
  input  logic [3:0]  bid,
  input  logic [1:0]  bresp,
  input  logic        bvalid,
  output logic        bready
);

  typedef enum logic [1:0] {R_IDLE = 2'd0, R_AR = 2'd1, R_R = 2'd2} rd_state_t;
  typedef enum logic [1:0] {W_IDLE = 2'd0, W_SEND = 2'd1, W_B = 2'd2} wr_state_t;

  rd_state_t   r_rd_state, w_rd_next;
  wr_state_t   r_wr_state, w_wr_next;

  logic [31:0] r_ar_addr;
  logic [1:0]  r_ar_size;
  logic [3:0]  r_arid;
  logic        r_rd_data;     // outstanding read belongs to the data port
  logic [31:0] r_aw_addr;
  logic [1:0]  r_aw_size;
  logic [31:0] r_wdata;
  logic        r_aw_done;
  logic        r_w_done;

  logic        w_data_rd_busy;
  logic        w_rd_acc_data;
  logic        w_rd_acc_inst;
  logic        w_wr_acc;
  logic        w_unused;

  // Response status and burst markers carry no information for single beats.
  assign w_unused = ^{rresp, bresp, rlast, bid};

  // The data port may have only one transaction in flight, read or write.
  assign w_data_rd_busy = (r_rd_state != R_IDLE) && r_rd_data;
  assign data_addr_ok   = (r_wr_state == W_IDLE) && !w_data_rd_busy &&
                          (data_wr || (r_rd_state == R_IDLE));
  assign w_rd_acc_data  = data_req && !data_wr && data_addr_ok;
  assign w_wr_acc       = data_req &&  data_wr && data_addr_ok;
  // A data read accepted this cycle takes priority over the inst port.
  assign inst_addr_ok   = (r_rd_state == R_IDLE) && !w_rd_acc_data;
  assign w_rd_acc_inst  = inst_req && inst_addr_ok;

  // Read channel field assignments
  assign arid    = r_arid;
  assign araddr  = r_ar_addr;
  assign arlen   = 8'd0;
  assign arsize  = {1'b0, r_ar_size};
  assign arburst = 2'b01;
  assign arlock  = 2'b00;
  assign arcache = 4'd0;
  assign arprot  = 3'd0;

  // Write channel field assignments
  assign awid    = ARID_DATA;
  assign awaddr  = r_aw_addr;
  assign awlen   = 8'd0;
  assign awsize  = {1'b0, r_aw_size};
  assign awburst = 2'b01;
  assign awlock  = 2'b00;
  assign awcache = 4'd0;
  assign awprot  = 3'd0;
  assign wid     = ARID_DATA;
  assign wdata   = r_wdata;
  assign wlast   = 1'b1;

  // Completion pulses are the R/B handshakes steered by ID.
  assign inst_rdata   = rdata;
  assign data_rdata   = rdata;
  assign inst_data_ok = rready && rvalid && (rid == ARID_INST);
  assign data_data_ok = (rready && rvalid && (rid == ARID_DATA)) ||
                        (bready && bvalid);

  // Byte lanes from the latched write size and low address bits
  always_comb begin
    wstrb = 4'b1111;
    case (r_aw_size)
      2'd0:    wstrb = 4'b0001 << r_aw_addr[1:0];
      2'd1:    wstrb = r_aw_addr[1] ? 4'b1100 : 4'b0011;
      default: wstrb = 4'b1111;
    endcase
  end

  // Read FSM state register
  always_ff @(posedge aclk or posedge areset) begin
    if (areset) r_rd_state <= R_IDLE;
    else        r_rd_state <= w_rd_next;
  end

  // Read FSM next state and handshake outputs
  always_comb begin
    w_rd_next = r_rd_state;
    arvalid   = 1'b0;
    rready    = 1'b0;
    case (r_rd_state)
      R_IDLE: if (w_rd_acc_inst || w_rd_acc_data) w_rd_next = R_AR;
      R_AR: begin
        arvalid = 1'b1;
        if (arready) w_rd_next = R_R;
      end
      R_R: begin
        rready = 1'b1;
        if (rvalid) w_rd_next = R_IDLE;
      end
      default: w_rd_next = R_IDLE;
    endcase
  end

  // Capture the accepted read request; fields stay stable until the next one
  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      r_ar_addr <= 32'd0;
      r_ar_size <= 2'd0;
      r_arid    <= 4'd0;
      r_rd_data <= 1'b0;
    end else if (w_rd_acc_data) begin
      r_ar_addr <= data_addr;
      r_ar_size <= data_size;
      r_arid    <= ARID_DATA;
      r_rd_data <= 1'b1;
    end else if (w_rd_acc_inst) begin
      r_ar_addr <= inst_addr;
      r_ar_size <= inst_size;
      r_arid    <= ARID_INST;
      r_rd_data <= 1'b0;
    end
  end

  // Write FSM state register
  always_ff @(posedge aclk or posedge areset) begin
    if (areset) r_wr_state <= W_IDLE;
    else        r_wr_state <= w_wr_next;
  end

  // Write FSM: AW and W run independently, B waits for both to finish
  always_comb begin
    w_wr_next = r_wr_state;
    awvalid   = 1'b0;
    wvalid    = 1'b0;
    bready    = 1'b0;
    case (r_wr_state)
      W_IDLE: if (w_wr_acc) w_wr_next = W_SEND;
      W_SEND: begin
        awvalid = !r_aw_done;
        wvalid  = !r_w_done;
        if ((r_aw_done || awready) && (r_w_done || wready)) w_wr_next = W_B;
      end
      W_B: begin
        bready = 1'b1;
        if (bvalid) w_wr_next = W_IDLE;
      end
      default: w_wr_next = W_IDLE;
    endcase
  end

  // Capture the accepted write request
  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      r_aw_addr <= 32'd0;
      r_aw_size <= 2'd0;
      r_wdata   <= 32'd0;
    end else if (w_wr_acc) begin
      r_aw_addr <= data_addr;
      r_aw_size <= data_size;
      r_wdata   <= data_wdata;
    end
  end

  // Remember which of AW / W has already handshaken in the current send
  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      r_aw_done <= 1'b0;
      r_w_done  <= 1'b0;
    end else if (r_wr_state == W_SEND) begin
      if (awvalid && awready) r_aw_done <= 1'b1;
      if (wvalid && wready)   r_w_done  <= 1'b1;
    end else begin
      r_aw_done <= 1'b0;
      r_w_done  <= 1'b0;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_sram_axi_bridge.sv
`default_nettype none
// ============================================================================
// Module      : tb_sram_axi_bridge
// Description : Directed self-checking bench for sram_axi_bridge; the bench
//               plays the AXI slave by hand, cycle by cycle.
// Revision    : 1.0  initial release
// ============================================================================
module tb_sram_axi_bridge;

  logic        aclk = 1'b0;
  logic        areset;
  logic        inst_req;
  logic [1:0]  inst_size;
  logic [31:0] inst_addr;
  logic        inst_addr_ok, inst_data_ok;
  logic [31:0] inst_rdata;
  logic        data_req, data_wr;
  logic [1:0]  data_size;
  logic [31:0] data_addr, data_wdata;
  logic        data_addr_ok, data_data_ok;
  logic [31:0] data_rdata;
  logic [3:0]  arid;
  logic [31:0] araddr;
  logic [7:0]  arlen;
  logic [2:0]  arsize;
  logic [1:0]  arburst, arlock;
  logic [3:0]  arcache;
  logic [2:0]  arprot;
  logic        arvalid, arready;
  logic [3:0]  rid;
  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic        rlast, rvalid, rready;
  logic [3:0]  awid;
  logic [31:0] awaddr;
  logic [7:0]  awlen;
  logic [2:0]  awsize;
  logic [1:0]  awburst, awlock;
  logic [3:0]  awcache;
  logic [2:0]  awprot;
  logic        awvalid, awready;
  logic [3:0]  wid;
  logic [31:0] wdata;
  logic [3:0]  wstrb;
  logic        wlast, wvalid, wready;
  logic [3:0]  bid;
  logic [1:0]  bresp;
  logic        bvalid, bready;

  int n_tests = 0;
  int n_fail  = 0;

  sram_axi_bridge #(.ARID_INST(4'd0), .ARID_DATA(4'd1)) dut (
    .aclk(aclk), .areset(areset),
    .inst_req(inst_req), .inst_size(inst_size), .inst_addr(inst_addr),
    .inst_addr_ok(inst_addr_ok), .inst_data_ok(inst_data_ok), .inst_rdata(inst_rdata),
    .data_req(data_req), .data_wr(data_wr), .data_size(data_size),
    .data_addr(data_addr), .data_wdata(data_wdata),
    .data_addr_ok(data_addr_ok), .data_data_ok(data_data_ok), .data_rdata(data_rdata),
    .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize), .arburst(arburst),
    .arlock(arlock), .arcache(arcache), .arprot(arprot), .arvalid(arvalid), .arready(arready),
    .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid), .rready(rready),
    .awid(awid), .awaddr(awaddr), .awlen(awlen), .awsize(awsize), .awburst(awburst),
    .awlock(awlock), .awcache(awcache), .awprot(awprot), .awvalid(awvalid), .awready(awready),
    .wid(wid), .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid), .wready(wready),
    .bid(bid), .bresp(bresp), .bvalid(bvalid), .bready(bready)
  );

  always #5 aclk = ~aclk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Advance to just after the next rising edge; new inputs are then applied
  // and allowed to settle before any check.
  task automatic cyc();
    @(posedge aclk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  initial begin
    areset = 1'b1;
    inst_req = 0; inst_size = 0; inst_addr = 0;
    data_req = 0; data_wr = 0; data_size = 0; data_addr = 0; data_wdata = 0;
    arready = 0; rid = 0; rdata = 0; rresp = 0; rlast = 0; rvalid = 0;
    awready = 0; wready = 0; bid = 0; bresp = 0; bvalid = 0;

    // ---------------- reset state ----------------
    cyc(); cyc();
    chk("rst_arvalid", arvalid, 0);
    chk("rst_rready", rready, 0);
    chk("rst_awvalid", awvalid, 0);
    chk("rst_wvalid", wvalid, 0);
    chk("rst_bready", bready, 0);
    chk("rst_araddr", araddr, 0);
    chk("rst_inst_data_ok", inst_data_ok, 0);
    chk("rst_data_data_ok", data_data_ok, 0);
    areset = 1'b0;

    // ---------------- inst read 0xBFC00000 ----------------
    cyc();
    inst_req = 1; inst_addr = 32'hBFC00000; inst_size = 2'd2; settle();
    chk("ir_addr_ok", inst_addr_ok, 1);
    cyc(); inst_req = 0; settle();
    chk("ir_arvalid", arvalid, 1);
    chk("ir_araddr", araddr, 32'hBFC00000);
    chk("ir_arid", arid, 0);
    chk("ir_arsize", arsize, 2);
    chk("ir_arlen", arlen, 0);
    chk("ir_arburst", arburst, 1);
    chk("ir_inst_addr_ok_busy", inst_addr_ok, 0);
    cyc();
    chk("ir_arvalid_hold", arvalid, 1);
    chk("ir_araddr_hold", araddr, 32'hBFC00000);
    arready = 1; settle();
    cyc(); arready = 0; settle();
    chk("ir_arvalid_drop", arvalid, 0);
    chk("ir_rready", rready, 1);
    chk("ir_no_early_ok", inst_data_ok, 0);
    rvalid = 1; rid = 4'd0; rdata = 32'h3C080001; settle();
    chk("ir_inst_data_ok", inst_data_ok, 1);
    chk("ir_inst_rdata", inst_rdata, 32'h3C080001);
    chk("ir_data_data_ok", data_data_ok, 0);
    cyc(); rvalid = 0; settle();
    chk("ir_ok_single", inst_data_ok, 0);
    chk("ir_rready_drop", rready, 0);

    // ---------------- byte write 0x80000003 ----------------
    data_req = 1; data_wr = 1; data_size = 0; data_addr = 32'h80000003;
    data_wdata = 32'h000000AA; settle();
    chk("bw_addr_ok", data_addr_ok, 1);
    cyc(); data_req = 0; settle();
    chk("bw_awvalid", awvalid, 1);
    chk("bw_wvalid", wvalid, 1);
    chk("bw_wstrb", wstrb, 4'b1000);
    chk("bw_awsize", awsize, 0);
    chk("bw_awaddr", awaddr, 32'h80000003);
    chk("bw_wdata", wdata, 32'h000000AA);
    chk("bw_wlast", wlast, 1);
    chk("bw_awid", awid, 1);
    chk("bw_wid", wid, 1);
    awready = 1; settle();                    // cycle 1: AW handshake
    cyc(); awready = 0; settle();
    chk("bw_awvalid_drop", awvalid, 0);
    chk("bw_wvalid_c2", wvalid, 1);
    chk("bw_bready_c2", bready, 0);
    cyc();
    chk("bw_wvalid_c3", wvalid, 1);
    wready = 1; settle();                     // cycle 3: W handshake
    cyc(); wready = 0; settle();
    chk("bw_wvalid_drop", wvalid, 0);
    chk("bw_bready", bready, 1);
    chk("bw_addr_ok_busy", data_addr_ok, 0);
    chk("bw_no_early_ok", data_data_ok, 0);
    bvalid = 1; settle();
    chk("bw_data_data_ok", data_data_ok, 1);
    cyc(); bvalid = 0; settle();
    chk("bw_ok_single", data_data_ok, 0);
    chk("bw_bready_drop", bready, 0);

    // ---------------- half write 0x80000002, AW+W same cycle, error resp ----
    data_req = 1; data_wr = 1; data_size = 1; data_addr = 32'h80000002;
    data_wdata = 32'hBEEF0000; settle();
    cyc(); data_req = 0; settle();
    chk("hw_wstrb", wstrb, 4'b1100);
    chk("hw_awsize", awsize, 1);
    awready = 1; wready = 1; settle();
    cyc(); awready = 0; wready = 0; settle();
    chk("hw_bready", bready, 1);
    bvalid = 1; bresp = 2'b10; settle();
    chk("hw_err_ok", data_data_ok, 1);
    cyc(); bvalid = 0; bresp = 0; settle();
    chk("hw_idle_addr_ok", data_addr_ok, 1);

    // ---------------- inst vs data read collision ----------------
    inst_req = 1; inst_addr = 32'h00001000; inst_size = 2;
    data_req = 1; data_wr = 0; data_size = 2; data_addr = 32'h80001000; settle();
    chk("col_data_addr_ok", data_addr_ok, 1);
    chk("col_inst_addr_ok", inst_addr_ok, 0);
    cyc(); data_req = 0; settle();
    chk("col_arid", arid, 1);
    chk("col_araddr", araddr, 32'h80001000);
    chk("col_inst_wait", inst_addr_ok, 0);
    arready = 1; settle();
    cyc(); arready = 0; settle();
    rvalid = 1; rid = 4'd1; rdata = 32'hDEADBEEF; settle();
    chk("col_data_data_ok", data_data_ok, 1);
    chk("col_data_rdata", data_rdata, 32'hDEADBEEF);
    chk("col_inst_data_ok", inst_data_ok, 0);
    cyc(); rvalid = 0; settle();
    chk("col_inst_accept", inst_addr_ok, 1);
    cyc(); inst_req = 0; settle();
    chk("col_inst_arid", arid, 0);
    chk("col_inst_araddr", araddr, 32'h00001000);
    arready = 1; settle();
    cyc(); arready = 0; rvalid = 1; rid = 4'd0; rdata = 32'h0000CAFE; settle();
    chk("col_inst_ok", inst_data_ok, 1);
    cyc(); rvalid = 0; settle();

    // ---------------- write outstanding blocks data read ----------------
    data_req = 1; data_wr = 1; data_size = 2; data_addr = 32'h00000020;
    data_wdata = 32'h12345678; settle();
    cyc(); data_req = 0; settle();
    chk("wb_wstrb", wstrb, 4'b1111);
    awready = 1; wready = 1; settle();
    cyc(); awready = 0; wready = 0;
    data_req = 1; data_wr = 0; data_size = 2; data_addr = 32'h80002000;
    inst_req = 1; inst_addr = 32'h00002000; inst_size = 2; settle();
    chk("wb_data_blocked", data_addr_ok, 0);
    chk("wb_inst_ok", inst_addr_ok, 1);
    cyc(); inst_req = 0; settle();
    chk("wb_blocked2", data_addr_ok, 0);
    chk("wb_inst_arid", arid, 0);
    chk("wb_inst_arvalid", arvalid, 1);
    arready = 1; settle();
    cyc(); arready = 0; rvalid = 1; rid = 4'd0; rdata = 32'h11112222; settle();
    chk("wb_inst_data_ok", inst_data_ok, 1);
    chk("wb_inst_rdata", inst_rdata, 32'h11112222);
    chk("wb_no_data_ok", data_data_ok, 0);
    chk("wb_blocked3", data_addr_ok, 0);
    cyc(); rvalid = 0; settle();
    chk("wb_blocked4", data_addr_ok, 0);
    bvalid = 1; settle();
    chk("wb_b_ok", data_data_ok, 1);
    chk("wb_blocked5", data_addr_ok, 0);
    cyc(); bvalid = 0; settle();
    chk("wb_unblocked", data_addr_ok, 1);

    // ---------------- reset in R_R ----------------
    cyc(); data_req = 0; settle();
    chk("rr_arid", arid, 1);
    arready = 1; settle();
    cyc(); arready = 0; settle();
    chk("rr_rready", rready, 1);
    #2; areset = 1; settle();
    chk("rr_rst_rready", rready, 0);
    chk("rr_rst_arvalid", arvalid, 0);
    rvalid = 1; rid = 4'd1; rdata = 32'h55555555; settle();
    chk("rr_rst_no_ok", data_data_ok, 0);
    chk("rr_rst_araddr", araddr, 0);
    cyc(); areset = 0; rvalid = 0; settle();
    chk("rr_post_no_ok", data_data_ok, 0);
    inst_req = 1; inst_addr = 32'hBFC00004; inst_size = 2; settle();
    chk("rr_post_addr_ok", inst_addr_ok, 1);
    cyc(); inst_req = 0; settle();
    chk("rr_post_araddr", araddr, 32'hBFC00004);
    arready = 1; settle();
    cyc(); arready = 0; rvalid = 1; rid = 4'd0; rdata = 32'h24080002; settle();
    chk("rr_post_inst_ok", inst_data_ok, 1);
    chk("rr_post_rdata", inst_rdata, 32'h24080002);
    cyc(); rvalid = 0; settle();
    chk("rr_post_single", inst_data_ok, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
